io_stress_err_monitor: RTL and testbench
========================================

// Module: io_stress_err_monitor
// PURPOSE
//  Downstream consumer of the array IO stress-test pattern checkers. Takes per-lane error
//  flags (one bit per checked bus/clock-rate lane; a flag is high in a cycle where the
//  received word mismatched the expected pattern). Runs a timed soak window, keeps
//  saturating per-lane error counts and sticky flags, and gives a pass/fail verdict,
//  a status LED and a simple indexed read port for bench/JTAG readout.
// PARAMETERS
//  NUM_LANES     8          number of error-flag lanes monitored
//  CNT_W         16         per-lane error counter width (saturating)
//  WIN_CYCLES    50000000   soak window length in CLK cycles (>=2)
//  BLINK_SHIFT   23         LED toggle period = 2^BLINK_SHIFT cycles in RUN
// PORTS
//  CLK        in   1                    monitor clock
//  RST        in   1                    async reset, active high
//  err_in     in   NUM_LANES            raw checker error flags; treated as async
//  arm        in   1                    1-cycle pulse: start soak window
//  clear      in   1                    1-cycle pulse: zero all counts/stickies, go IDLE
//  rd_req     in   1                    read request pulse
//  rd_sel     in   $clog2(NUM_LANES)    lane index for read
//  rd_ack     out  1                    read data valid, 1-cycle pulse
//  rd_data    out  CNT_W                error count of selected lane
//  sticky     out  NUM_LANES            lane has seen >=1 counted error
//  window_done out 1                    high while in DONE
//  pass       out  1                    high in DONE when sticky==0
//  led        out  1                    status indicator
// BEHAVIOUR
//  - Reset: state=IDLE; all counters, sticky, rd_ack, rd_data, window_done, pass, led = 0.
//    Async assert, sync deassert at a CLK edge; reset mid-window aborts the run, no residue.
//  - err_in passes through a 2-flop synchronizer per lane (2-cycle latency) before use.
//  - FSM: IDLE -arm-> RUN; RUN -window count reaches WIN_CYCLES-1-> DONE;
//    any state -clear-> IDLE. arm in RUN or DONE is ignored. clear and arm in the same
//    cycle: clear wins, stays IDLE.
//  - Window counter zeroed on entering RUN; RUN lasts exactly WIN_CYCLES cycles.
//  - Counting: only in RUN, for each cycle where the synchronized flag is 1, the lane counter
//    increments by 1, saturating at 2^CNT_W-1 (holds, never wraps). sticky[i] is set on the
//    first counted error and held until clear/RST. Flags outside RUN are not counted.
//  - Counts and sticky are held through DONE and through a subsequent IDLE; only clear or
//    RST zeroes them. A new arm without clear accumulates on top of existing counts.
//  - clear same cycle as a counted error: clear wins, counter ends at 0.
//  - pass = (state==DONE) && (sticky==0); window_done = (state==DONE).
//  - Read: rd_req sampled every cycle; rd_ack asserted exactly 1 cycle later with rd_data =
//    count[rd_sel] as of the request cycle. rd_sel >= NUM_LANES returns 0 with rd_ack.
//    Back-to-back requests each get their own ack. rd_data holds between acks. Reads are
//    legal in any state and do not disturb counting.
//  - LED: IDLE = 0; RUN = toggles every 2^BLINK_SHIFT cycles (starts 0 on entry);
//    DONE = solid 1 if pass, else toggles every 2^(BLINK_SHIFT-3) cycles.
// TESTING (sim with WIN_CYCLES=100, BLINK_SHIFT=4, CNT_W=4, NUM_LANES=4)
//  - Clean run: arm, err_in=0 -> window_done rises 100 cycles after RUN entry, pass=1,
//    sticky=0, led solid 1, all reads return 0.
//  - Single error: err_in[2]=1 for 3 cycles mid-window -> sticky=4'b0100, pass=0,
//    read lane 2 -> rd_ack next cycle, rd_data=3; lane 0 -> 0.
//  - Saturation: err_in[1] held high all window -> count[1]=15 (not wrapped), sticky[1]=1.
//  - Gating/priority: err pulses in IDLE and DONE not counted; clear+arm same cycle stays
//    IDLE; clear+error same cycle leaves count 0.
//  - Read edge: rd_sel=5 -> rd_ack with rd_data=0; back-to-back rd_req -> two acks.
//  - Reset mid-RUN: assert RST at cycle 50 -> all outputs 0 immediately, state IDLE,
//    needs new arm.

Source files
------------

// File: rtl/io_stress_err_monitor.sv
// Purpose: soak-window monitor for IO stress checker error flags; saturating per-lane counts, sticky flags, verdict, LED, read port.
// Latency: err_in_i reaches the counters after a 2-flop synchronizer; rd_ack_o/rd_data_o follow rd_req_i by exactly 1 cycle.
// Backpressure: none; every rd_req_i gets its own ack, inputs are sampled every cycle and never stalled.
module io_stress_err_monitor #(
    parameter int NUM_LANES   = 8,
    parameter int CNT_W       = 16,
    parameter int WIN_CYCLES  = 50000000,
    parameter int BLINK_SHIFT = 23,                  // must be >= 4 so the fast DONE blink has a counter slice
    parameter int SEL_W       = $clog2(NUM_LANES)    // widen to exercise out-of-range lane selects
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_LANES-1:0] err_in_i,
    input  logic                 arm_i,
    input  logic                 clear_i,
    input  logic                 rd_req_i,
    input  logic [SEL_W-1:0]     rd_sel_i,
    output logic                 rd_ack_o,
    output logic [CNT_W-1:0]     rd_data_o,
    output logic [NUM_LANES-1:0] sticky_o,
    output logic                 window_done_o,
    output logic                 pass_o,
    output logic                 led_o
);

    localparam int               WIN_W    = (WIN_CYCLES > 2) ? $clog2(WIN_CYCLES) : 1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam int               FAST_W   = BLINK_SHIFT - 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [NUM_LANES-1:0]   err_meta_q, err_sync_q;
    logic [WIN_W-1:0]       win_q;
    logic [CNT_W-1:0]       cnt_q [NUM_LANES];
    logic [NUM_LANES-1:0]   sticky_q;
    logic [CNT_W-1:0]       rd_mux;
    logic                   rd_ack_q;
    logic [CNT_W-1:0]       rd_data_q;
    logic [BLINK_SHIFT-1:0] blink_q;
    logic                   tog_q;

    // Two-flop synchronizer per lane: checker flags come from another clock domain.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_meta_q <= '0;
            err_sync_q <= '0;
        end else begin
            err_meta_q <= err_in_i;
            err_sync_q <= err_meta_q;
        end
    end

    // State register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next state: clear beats everything, arm only honoured from IDLE.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (arm_i) state_d = ST_RUN;
                ST_RUN:  if (win_q == WIN_LAST) state_d = ST_DONE;
                ST_DONE: state_d = ST_DONE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Window counter: zero outside RUN so every RUN entry starts at 0 and lasts WIN_CYCLES cycles.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)                                       win_q <= '0;
        else if (state_q == ST_RUN && state_d == ST_RUN) win_q <= win_q + 1'b1;
        else                                             win_q <= '0;
    end

    // Per-lane saturating error counts and sticky flags; only RUN counts, clear wins over a same-cycle error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_LANES; i++) cnt_q[i] <= '0;
            sticky_q <= '0;
        end else if (clear_i) begin
            for (int i = 0; i < NUM_LANES; i++) cnt_q[i] <= '0;
            sticky_q <= '0;
        end else if (state_q == ST_RUN) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                if (err_sync_q[i]) begin
                    sticky_q[i] <= 1'b1;
                    if (cnt_q[i] != CNT_MAX) cnt_q[i] <= cnt_q[i] + 1'b1;
                end
            end
        end
    end

    // Lane select mux; any select that matches no lane reads as zero.
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (rd_sel_i == SEL_W'(i)) rd_mux = cnt_q[i];
        end
    end

    // Read port: ack one cycle after each request, data captured from the request cycle and held until the next ack.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ack_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_ack_q <= rd_req_i;
            if (rd_req_i) rd_data_q <= rd_mux;
        end
    end

    // Blink timebase: restarts on every state change so RUN and DONE blinking begin from 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            blink_q <= '0;
            tog_q   <= 1'b0;
        end else if (state_d != state_q || state_q == ST_IDLE) begin
            blink_q <= '0;
            tog_q   <= 1'b0;
        end else begin
            blink_q <= blink_q + 1'b1;
            if (state_q == ST_RUN && (&blink_q))                    tog_q <= ~tog_q;
            else if (state_q == ST_DONE && (&blink_q[FAST_W-1:0])) tog_q <= ~tog_q;
        end
    end

    // Outputs decoded from state: verdict, done flag and LED pattern.
    always_comb begin
        window_done_o = (state_q == ST_DONE);
        pass_o        = (state_q == ST_DONE) && (sticky_q == '0);
        case (state_q)
            ST_RUN:  led_o = tog_q;
            ST_DONE: led_o = (sticky_q == '0) ? 1'b1 : tog_q;
            default: led_o = 1'b0;
        endcase
    end

    assign sticky_o  = sticky_q;
    assign rd_ack_o  = rd_ack_q;
    assign rd_data_o = rd_data_q;

endmodule

// File: tb/tb_io_stress_err_monitor.sv
// Purpose: randomized scoreboard bench for io_stress_err_monitor against a transaction-level reference model.
// Latency: model assumes 2-cycle flag synchronization and 1-cycle read ack.
// Backpressure: n/a; the read monitor pops one expected value per observed ack.
module tb_io_stress_err_monitor;

    localparam int NL  = 4;
    localparam int CW  = 4;
    localparam int WIN = 100;
    localparam int BS  = 4;
    localparam int SW  = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NL-1:0] err_in = '0;
    logic          arm = 1'b0, clear = 1'b0, rd_req = 1'b0;
    logic [SW-1:0] rd_sel = '0;
    logic          rd_ack, window_done, pass, led;
    logic [CW-1:0] rd_data;
    logic [NL-1:0] sticky;

    io_stress_err_monitor #(
        .NUM_LANES(NL), .CNT_W(CW), .WIN_CYCLES(WIN), .BLINK_SHIFT(BS), .SEL_W(SW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .err_in_i(err_in), .arm_i(arm), .clear_i(clear),
        .rd_req_i(rd_req), .rd_sel_i(rd_sel), .rd_ack_o(rd_ack), .rd_data_o(rd_data),
        .sticky_o(sticky), .window_done_o(window_done), .pass_o(pass), .led_o(led)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_q[$];

    // Reference model: mode 0=idle 1=run 2=done; counts kept as plain integers.
    int            m_mode, m_left, m_k;
    int            m_cnt[NL];
    logic [NL-1:0] m_sticky, m_e1, m_e2;
    int            last_rd;

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int exp_led();
        if (m_mode == 1) return (m_k / (1 << BS)) % 2;
        if (m_mode == 2) return (m_sticky == '0) ? 1 : (m_k / (1 << (BS - 3))) % 2;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_k = 0;
        for (int i = 0; i < NL; i++) m_cnt[i] = 0;
        m_sticky = '0; m_e1 = '0; m_e2 = '0;
        last_rd = 0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, advance the model across the edge, check status after the edge.
    task automatic cyc(input logic a, input logic c, input logic [NL-1:0] e,
                       input logic rq, input logic [SW-1:0] sel);
        int prev, pend;
        arm = a; clear = c; err_in = e; rd_req = rq; rd_sel = sel;
        pend = 0;
        if (rq) begin
            pend = (int'(sel) < NL) ? m_cnt[sel] : 0;
            exp_q.push_back(pend);
        end
        if (c) begin
            for (int i = 0; i < NL; i++) m_cnt[i] = 0;
            m_sticky = '0;
        end else if (m_mode == 1) begin
            for (int i = 0; i < NL; i++) begin
                if (m_e2[i]) begin
                    m_sticky[i] = 1'b1;
                    if (m_cnt[i] < (1 << CW) - 1) m_cnt[i]++;
                end
            end
        end
        prev = m_mode;
        if (c) m_mode = 0;
        else if (m_mode == 0 && a) begin m_mode = 1; m_left = WIN; end
        else if (m_mode == 1) begin
            m_left--;
            if (m_left == 0) m_mode = 2;
        end
        if (m_mode != prev) m_k = 0; else m_k++;
        m_e2 = m_e1; m_e1 = e;
        @(posedge clk); #1;
        chk("window_done", int'(window_done), (m_mode == 2) ? 1 : 0);
        chk("pass", int'(pass), (m_mode == 2 && m_sticky == '0) ? 1 : 0);
        chk("sticky", int'(sticky), int'(m_sticky));
        chk("led", int'(led), exp_led());
        chk("rd_ack_timing", int'(rd_ack), int'(rq));
        if (rq) last_rd = pend;
        else    chk("rd_data_hold", int'(rd_data), last_rd);
    endtask

    task automatic idle_n(input int n, input logic [NL-1:0] e);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, e, 1'b0, '0);
    endtask

    task automatic read_all();
        for (int i = 0; i < NL; i++) cyc(1'b0, 1'b0, '0, 1'b1, SW'(i));
        cyc(1'b0, 1'b0, '0, 1'b0, '0);
    endtask

    task automatic hit_reset();
        rst = 1'b1;
        #1;
        chk("rst_window_done", int'(window_done), 0);
        chk("rst_pass", int'(pass), 0);
        chk("rst_led", int'(led), 0);
        chk("rst_sticky", int'(sticky), 0);
        chk("rst_rd_ack", int'(rd_ack), 0);
        chk("rst_rd_data", int'(rd_data), 0);
        model_reset();
        arm = 1'b0; clear = 1'b0; err_in = '0; rd_req = 1'b0; rd_sel = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Read scoreboard monitor: every ack pops the value the model predicted at request time.
    always @(negedge clk) begin
        if (!rst && rd_ack) begin
            if (exp_q.size() == 0) chk("rd_ack_unexpected", 1, 0);
            else                   chk("rd_data", int'(rd_data), exp_q.pop_front());
        end
    end

    initial begin
        model_reset();
        #2;
        hit_reset();

        // Clean run with random reads sprinkled through the window.
        cyc(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 105; i++)
            cyc(1'b0, 1'b0, '0, 1'($urandom_range(0, 1)), SW'($urandom_range(0, NL - 1)));
        read_all();
        chk("clean_pass", int'(pass), 1);
        chk("clean_led", int'(led), 1);

        // Single error burst on lane 2 mid-window.
        cyc(1'b0, 1'b1, '0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0);
        idle_n(30, '0);
        idle_n(3, 4'b0100);
        idle_n(75, '0);
        read_all();
        chk("single_sticky", int'(sticky), 4'b0100);
        chk("single_pass", int'(pass), 0);

        // Saturation: lane 1 held high for the whole window.
        cyc(1'b0, 1'b1, '0, 1'b0, '0);
        cyc(1'b1, 1'b0, 4'b0010, 1'b0, '0);
        idle_n(102, 4'b0010);
        idle_n(4, '0);
        read_all();
        chk("sat_sticky1", int'(sticky[1]), 1);

        // Gating: errors in IDLE and DONE are ignored.
        cyc(1'b0, 1'b1, '0, 1'b0, '0);
        idle_n(5, 4'b1111);
        idle_n(3, '0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0);
        idle_n(102, '0);
        idle_n(5, 4'b1111);
        idle_n(3, '0);
        read_all();
        chk("gate_pass", int'(pass), 1);

        // clear and arm together: stays IDLE.
        cyc(1'b1, 1'b1, '0, 1'b0, '0);
        idle_n(110, '0);
        chk("clr_arm_idle", int'(window_done), 0);

        // clear in the same cycle a lane-0 error would be counted.
        cyc(1'b1, 1'b0, '0, 1'b0, '0);
        idle_n(10, '0);
        cyc(1'b0, 1'b0, 4'b0001, 1'b0, '0);
        cyc(1'b0, 1'b0, '0, 1'b0, '0);
        cyc(1'b0, 1'b1, '0, 1'b0, '0);
        read_all();
        chk("clr_err_sticky", int'(sticky), 0);

        // Read edges: out-of-range select and back-to-back requests.
        cyc(1'b0, 1'b0, '0, 1'b1, 3'd5);
        cyc(1'b0, 1'b0, '0, 1'b1, 3'd3);
        cyc(1'b0, 1'b0, '0, 1'b1, 3'd7);
        idle_n(2, '0);

        // Randomized runs with random flags, reads and occasional arm/clear.
        for (int r = 0; r < 4; r++) begin
            if ($urandom_range(0, 1) == 1) cyc(1'b0, 1'b1, '0, 1'b0, '0);
            cyc(1'b1, 1'b0, '0, 1'b0, '0);
            for (int i = 0; i < 130; i++) begin
                cyc(1'($urandom_range(0, 49) == 0), 1'($urandom_range(0, 199) == 0),
                    ($urandom_range(0, 5) == 0) ? NL'($urandom) : '0,
                    1'($urandom_range(0, 2) == 0), SW'($urandom_range(0, 7)));
            end
            read_all();
        end

        // Reset in the middle of a run: aborts, needs a new arm.
        cyc(1'b0, 1'b1, '0, 1'b0, '0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0);
        for (int i = 0; i < 50; i++) cyc(1'b0, 1'b0, NL'($urandom), 1'b0, '0);
        hit_reset();
        idle_n(110, '0);
        read_all();
        chk("post_rst_idle", int'(window_done), 0);
        cyc(1'b1, 1'b0, '0, 1'b0, '0);
        idle_n(102, '0);
        chk("post_rst_pass", int'(pass), 1);

        idle_n(2, '0);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
